prg_loader: RTL and testbench
=============================

Name: prg_loader

Overview:
- Converts a PRG file streamed from hps_io into byte writes on the pet2001hw DMA port.
- A PRG file is a 2-byte little-endian load address followed by the payload.
- After the last byte, patches the BASIC end-of-program pointers so that RUN works without a reset.
- Sits between hps_io (ioctl_*) and pet2001hw (dma_*). Replaces the inline loader logic in emu and adds buffering with backpressure.

Parameters:
- PRG_INDEX, 8'h41: ioctl_index value that selects this loader.
- RAM_TOP, 16'h8000: first address that must not be written; bytes at or above it are dropped.
- PTR_BASE, 16'h002A: first pointer byte to patch. Six bytes are patched: PTR_BASE..PTR_BASE+5 (VARTAB/ARYTAB/STREND).
- FIFO_DEPTH, 4: entries in the {addr,data} write buffer; power of two, at least 4.

Ports:
- clk, in, 1: system clock (clk_sys).
- reset, in, 1: synchronous, active-high.
- ioctl_download, in, 1: hps_io transfer active.
- ioctl_index, in, 8: file index.
- ioctl_wr, in, 1: byte strobe, one cycle.
- ioctl_addr, in, 25: byte offset in file.
- ioctl_dout, in, 8: file byte.
- ioctl_wait, out, 1: backpressure to hps_io.
- dma_slot, in, 1: DMA write permitted this cycle (tied to a CPU-idle ce phase).
- dma_addr, out, 16: write address.
- dma_dout, out, 8: write data.
- dma_we, out, 1: write strobe, one cycle.
- busy, out, 1: load or patch in progress.
- load_err, out, 1: sticky; set on truncated file or RAM_TOP overflow.
- load_end, out, 16: first address past the last written byte.

Behaviour:
- Reset: state IDLE, FIFO empty, and all outputs 0 (ioctl_wait, dma_we, dma_addr, dma_dout, busy, load_err, load_end).
- Reset mid-load abandons the transfer. No patch writes are issued.
- Active means ioctl_download && ioctl_index==PRG_INDEX. Downloads with any other index are ignored: no FIFO activity and no output change.
- Start condition: a rising edge of the active condition, in any state.
  - Flushes the FIFO and clears load_err and load_end.
  - Aborts any patch in progress and enters HDR_LO.
- FSM:
  - IDLE → HDR_LO on start.
  - HDR_LO: an ioctl_wr latches addr[7:0] → HDR_HI.
  - HDR_HI: an ioctl_wr latches addr[15:8] → DATA.
  - DATA: each ioctl_wr with addr<RAM_TOP pushes {addr,byte} and increments addr.
    - With addr>=RAM_TOP the byte is dropped, addr is held, and load_err is set.
  - DATA → DRAIN when the active condition falls.
  - DRAIN: wait for the FIFO to empty, then load_end<=addr → PATCH.
  - PATCH: six writes to PTR_BASE+0..5 with data lo,hi,lo,hi,lo,hi of load_end. One write is issued per dma_slot → IDLE.
  - Active falling in HDR_LO or HDR_HI: set load_err, no patch → IDLE.
- Header bytes are recognised by FSM position, not by ioctl_addr. ioctl_addr is ignored except as informational.
- FIFO and ioctl_wait:
  - Push and pop may occur in the same cycle; the count is unchanged.
  - ioctl_wait is registered and equals (count after this edge >= FIFO_DEPTH-1). This leaves room for one ioctl_wr that arrives in the cycle after wait rises.
  - The FIFO never overflows. A push into a full FIFO is a design error (assertion).
- DMA timing:
  - On an edge where dma_slot=1 and a write source is available (FIFO non-empty in DATA/DRAIN, or a pending patch in PATCH), register dma_addr/dma_dout and pulse dma_we for exactly the next cycle.
  - The FIFO pops at that edge.
  - dma_addr/dma_dout hold their values after dma_we falls.
- Minimum latency from ioctl_wr to dma_we is 2 cycles, with dma_slot held high.
- Write ordering is preserved. Patch writes follow all data writes.
- addr arithmetic is 16-bit. Wrap cannot occur because RAM_TOP<=16'h8000 stops the increment first.
- load_end with zero payload bytes equals the header address; the patch still executes.
- busy = (state != IDLE).

Test Plan:
- Normal load: file 01 04 AA BB CC, dma_slot=1 → writes 0401=AA, 0402=BB, 0403=CC, then 002A..002F = 04,04,04,04,04,04 (load_end=0404); load_err=0; busy falls after the final write.
- Backpressure: 8 data bytes with dma_slot=0 → ioctl_wait=1 once 3 entries are queued. Then release dma_slot → all 8 written in order, no byte lost, ioctl_wait falls at count<3.
- Overflow: header FE 7F, payload 11 22 33 → writes 7FFE=11, 7FFF=22; 33 dropped; load_err=1; pointers patched with 8000.
- Truncated: a file of a single byte 01 → no dma_we at all; load_err=1; state IDLE.
- Reset mid-load: assert reset after 2 payload bytes → outputs 0 the next cycle, no patch writes; a later normal load behaves as in the first scenario.
- Foreign index: ioctl_index=0 with data streamed → dma_we, ioctl_wait, and busy stay 0.

Source files
------------

// File: rtl/prg_loader.sv
// PRG file loader: turns an hps_io byte stream (2-byte LE load address + payload)
// into buffered DMA byte writes, then patches the BASIC end-of-program pointers.
//
// state  | meaning
// IDLE   | no load in progress
// HDR_LO | waiting for load address low byte
// HDR_HI | waiting for load address high byte
// DATA   | payload bytes queued into the write FIFO
// DRAIN  | download ended, emptying the FIFO
// PATCH  | writing load_end into VARTAB/ARYTAB/STREND
module prg_loader #(
    parameter logic [7:0]  PRG_INDEX  = 8'h41,
    parameter logic [15:0] RAM_TOP    = 16'h8000,
    parameter logic [15:0] PTR_BASE   = 16'h002A,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    input  logic        dma_slot,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_dout,
    output logic        dma_we,
    output logic        busy,
    output logic        load_err,
    output logic [15:0] load_end
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] WAIT_LEVEL = CW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] FULL_LEVEL = CW'(FIFO_DEPTH);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] HDR_LO = 3'd1;
    localparam logic [2:0] HDR_HI = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] DRAIN  = 3'd4;
    localparam logic [2:0] PATCH  = 3'd5;

    logic [2:0]    state;
    logic          active, active_q, start, fall;
    logic [15:0]   addr;
    logic [2:0]    patch_idx;
    logic [15:0]   fifo_addr [FIFO_DEPTH];
    logic [7:0]    fifo_data [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic          push, drop, pop, patch_go;
    logic          unused_ok;

    // The file offset is informational only; header bytes are found by FSM position.
    assign unused_ok = ^ioctl_addr;

    assign active   = ioctl_download && (ioctl_index == PRG_INDEX);
    assign start    = active && !active_q;
    assign fall     = !active && active_q;
    assign push     = !start && (state == DATA) && active && ioctl_wr && (addr < RAM_TOP);
    assign drop     = !start && (state == DATA) && active && ioctl_wr && (addr >= RAM_TOP);
    assign pop      = !start && dma_slot && (count != '0) && ((state == DATA) || (state == DRAIN));
    assign patch_go = !start && dma_slot && (state == PATCH);
    assign busy     = (state != IDLE);

    always_comb begin
        count_next = count;
        if (start)
            count_next = '0;
        else if (push && !pop)
            count_next = count + 1'b1;
        else if (pop && !push)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= addr;
            fifo_data[wr_ptr] <= ioctl_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            active_q   <= 1'b0;
            addr       <= '0;
            patch_idx  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ioctl_wait <= 1'b0;
            dma_we     <= 1'b0;
            dma_addr   <= '0;
            dma_dout   <= '0;
            load_err   <= 1'b0;
            load_end   <= '0;
        end else begin
            active_q   <= active;
            count      <= count_next;
            // Raised one entry early so a strobe already in flight still fits.
            ioctl_wait <= (count_next >= WAIT_LEVEL);
            dma_we     <= 1'b0;
            if (start) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                patch_idx <= '0;
                load_err  <= 1'b0;
                load_end  <= '0;
                state     <= HDR_LO;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop) begin
                    rd_ptr   <= rd_ptr + 1'b1;
                    dma_we   <= 1'b1;
                    dma_addr <= fifo_addr[rd_ptr];
                    dma_dout <= fifo_data[rd_ptr];
                end
                if (drop)
                    load_err <= 1'b1;
                case (state)
                    HDR_LO: begin
                        if (fall) begin
                            load_err <= 1'b1;
                            state    <= IDLE;
                        end else if (active && ioctl_wr) begin
                            addr[7:0] <= ioctl_dout;
                            state     <= HDR_HI;
                        end
                    end
                    HDR_HI: begin
                        if (fall) begin
                            load_err <= 1'b1;
                            state    <= IDLE;
                        end else if (active && ioctl_wr) begin
                            addr[15:8] <= ioctl_dout;
                            state      <= DATA;
                        end
                    end
                    DATA: begin
                        if (fall)
                            state <= DRAIN;
                        else if (push)
                            addr <= addr + 16'd1;
                    end
                    DRAIN: begin
                        if (count == '0) begin
                            load_end  <= addr;
                            patch_idx <= '0;
                            state     <= PATCH;
                        end
                    end
                    PATCH: begin
                        if (patch_go) begin
                            dma_we   <= 1'b1;
                            dma_addr <= PTR_BASE + {13'd0, patch_idx};
                            dma_dout <= patch_idx[0] ? load_end[15:8] : load_end[7:0];
                            if (patch_idx == 3'd5)
                                state <= IDLE;
                            else
                                patch_idx <= patch_idx + 3'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            assert (!(push && count == FULL_LEVEL));
    end
endmodule

// File: tb/tb_prg_loader.sv
// Scoreboard bench for prg_loader: directed PRG files, expected DMA writes queued
// by the stimulus and matched by an independent write monitor.
module tb_prg_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'h00;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = 8'h00;
    logic        ioctl_wait;
    logic        dma_slot = 1'b0;
    logic [15:0] dma_addr;
    logic [7:0]  dma_dout;
    logic        dma_we;
    logic        busy;
    logic        load_err;
    logic [15:0] load_end;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;
    wr_t exp_q[$];

    prg_loader dut (
        .clk(clk), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait), .dma_slot(dma_slot),
        .dma_addr(dma_addr), .dma_dout(dma_dout), .dma_we(dma_we),
        .busy(busy), .load_err(load_err), .load_end(load_end)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        wr_t e;
        if (dma_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write actual=%h:%h required=none", dma_addr, dma_dout);
            end else begin
                e = exp_q.pop_front();
                if ({dma_addr, dma_dout} !== {e.a, e.d}) begin
                    errors++;
                    $display("FAIL dma_write actual=%h:%h required=%h:%h", dma_addr, dma_dout, e.a, e.d);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic expect_wr(input logic [15:0] a, input logic [7:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic expect_patch(input logic [15:0] le);
        for (int i = 0; i < 6; i++)
            expect_wr(16'h002A + 16'(i), (i % 2 == 1) ? le[15:8] : le[7:0]);
    endtask

    task automatic start_dl(input logic [7:0] idx);
        ioctl_index = idx;
        ioctl_addr = '0;
        ioctl_download = 1'b1;
        tick();
    endtask

    task automatic end_dl();
        ioctl_download = 1'b0;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (ioctl_wait === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL wait_timeout actual=%0d required=<200", n);
        end
        ioctl_wr = 1'b1;
        ioctl_dout = b;
        tick();
        ioctl_wr = 1'b0;
        ioctl_addr = ioctl_addr + 25'd1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && n < 500) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check({name, "_timeout"}, (n < 500) ? 1 : 0, 1);
        check({name, "_left"}, exp_q.size(), 0);
        check({name, "_busy"}, busy, 0);
    endtask

    task automatic normal_load(input string name);
        dma_slot = 1'b1;
        expect_wr(16'h0401, 8'hAA);
        expect_wr(16'h0402, 8'hBB);
        expect_wr(16'h0403, 8'hCC);
        expect_patch(16'h0404);
        start_dl(8'h41);
        send_byte(8'h01);
        send_byte(8'h04);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        end_dl();
        wait_idle(name);
        check({name, "_err"}, load_err, 0);
        check({name, "_end"}, load_end, 16'h0404);
    endtask

    initial begin
        repeat (3) tick();
        check("rst_wait", ioctl_wait, 0);
        check("rst_we", dma_we, 0);
        check("rst_addr", dma_addr, 0);
        check("rst_dout", dma_dout, 0);
        check("rst_busy", busy, 0);
        check("rst_err", load_err, 0);
        check("rst_end", load_end, 0);
        reset = 1'b0;
        tick();

        normal_load("normal");

        // Backpressure: slot held off, three entries queued raise wait.
        dma_slot = 1'b0;
        for (int i = 0; i < 8; i++)
            expect_wr(16'h1000 + 16'(i), 8'h10 + 8'(i));
        expect_patch(16'h1008);
        start_dl(8'h41);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h10);
        send_byte(8'h11);
        check("bp_wait_at2", ioctl_wait, 0);
        send_byte(8'h12);
        check("bp_wait_at3", ioctl_wait, 1);
        repeat (4) tick();
        check("bp_wait_held", ioctl_wait, 1);
        dma_slot = 1'b1;
        tick();
        check("bp_wait_fall", ioctl_wait, 0);
        for (int i = 3; i < 8; i++)
            send_byte(8'h10 + 8'(i));
        end_dl();
        wait_idle("bp");
        check("bp_err", load_err, 0);
        check("bp_end", load_end, 16'h1008);

        // Overflow at RAM_TOP.
        expect_wr(16'h7FFE, 8'h11);
        expect_wr(16'h7FFF, 8'h22);
        expect_patch(16'h8000);
        start_dl(8'h41);
        send_byte(8'hFE);
        send_byte(8'h7F);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        end_dl();
        wait_idle("ovf");
        check("ovf_err", load_err, 1);
        check("ovf_end", load_end, 16'h8000);

        // Zero-length payload still patches with the header address.
        expect_patch(16'h3000);
        start_dl(8'h41);
        send_byte(8'h00);
        send_byte(8'h30);
        end_dl();
        wait_idle("empty");
        check("empty_end", load_end, 16'h3000);
        check("empty_err", load_err, 0);

        // Truncated: one header byte only.
        start_dl(8'h41);
        send_byte(8'h01);
        end_dl();
        repeat (10) tick();
        check("trunc_err", load_err, 1);
        check("trunc_busy", busy, 0);

        // Reset mid-load drops everything.
        dma_slot = 1'b0;
        start_dl(8'h41);
        send_byte(8'h00);
        send_byte(8'h20);
        send_byte(8'h55);
        send_byte(8'h66);
        reset = 1'b1;
        ioctl_download = 1'b0;
        tick();
        check("mrst_wait", ioctl_wait, 0);
        check("mrst_we", dma_we, 0);
        check("mrst_addr", dma_addr, 0);
        check("mrst_dout", dma_dout, 0);
        check("mrst_busy", busy, 0);
        check("mrst_err", load_err, 0);
        check("mrst_end", load_end, 0);
        reset = 1'b0;
        dma_slot = 1'b1;
        repeat (12) tick();
        check("mrst_idle", busy, 0);
        normal_load("after_rst");

        // Foreign index is ignored.
        start_dl(8'h00);
        send_byte(8'h00);
        send_byte(8'h50);
        for (int i = 0; i < 6; i++)
            send_byte(8'hE0 + 8'(i));
        check("foreign_busy", busy, 0);
        check("foreign_wait", ioctl_wait, 0);
        end_dl();
        repeat (10) tick();
        check("foreign_busy_end", busy, 0);
        check("foreign_end", load_end, 16'h0404);
        check("foreign_left", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
